// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that shares one registered single-precision adder among
// NUM_REQ requesters, one operation in flight, result returned with requester id.
module fp_add_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FPU_LATENCY = 1,
  localparam int ID_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic [31:0]           fpu_a,
  output logic [31:0]           fpu_b,
  input  logic [31:0]           fpu_out
);

  localparam int CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY + 1) : 1;

  // Handshakes: a request transfers on the edge where req_valid[i] & req_ready[i];
  // a response transfers on the edge where rsp_valid & rsp_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       fpu_a_q, fpu_a_d;
  logic [31:0]       fpu_b_q, fpu_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]       rsp_data_q, rsp_data_d;

  logic [31:0]       a_arr [NUM_REQ];
  logic [31:0]       b_arr [NUM_REQ];
  logic [ID_W-1:0]   scan_idx;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[32*i +: 32];
      b_arr[i] = req_b[32*i +: 32];
    end
  end

  // Search starts at ptr and wraps; recomputed every cycle so withdrawn requests drop out.
  always_comb begin
    scan_idx    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    req_ready   = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
          fpu_a_d   = a_arr[grant_idx];
          fpu_b_d   = b_arr[grant_idx];
          rsp_id_d  = grant_idx;
          cnt_d     = CNT_W'(FPU_LATENCY);
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = fpu_out;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Nothing may be accepted while reset is held, even though the state is IDLE.
    if (!rst_n) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: a lookup-table adder model stands in for the FPU,
// expected responses are queued by the driver and popped by a response monitor.
module tb_fp_add_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int EW      = ID_W + 32;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic [31:0]           fpu_a;
  logic [31:0]           fpu_b;
  logic [31:0]           fpu_out;

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  fp_add_arbiter #(.NUM_REQ(NUM_REQ), .FPU_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_out(fpu_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Single-cycle registered adder; sums are hand-computed IEEE-754 values.
  function automatic logic [31:0] add_lut(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1 + 2 = 3
      {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1 + 1 = 2
      {32'h3F000000, 32'h3E800000}: return 32'h3F400000; // 0.5 + 0.25 = 0.75
      {32'h40400000, 32'h40800000}: return 32'h40E00000; // 3 + 4 = 7
      {32'hBF800000, 32'h3F800000}: return 32'h00000000; // -1 + 1 = 0
      {32'h41200000, 32'hC0800000}: return 32'h40C00000; // 10 + -4 = 6
      default:                      return 32'h7FC00000;
    endcase
  endfunction

  always @(posedge clk) fpu_out <= add_lut(fpu_a, fpu_b);

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("rsp_drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got id %0d data %h expected no response", rsp_id, rsp_data);
      end else begin
        check("rsp", 64'({rsp_id, rsp_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  int   gidx [5];
  int   gcyc [5];
  int   ng;
  int   order [5] = '{0, 1, 2, 3, 0};
  logic saw_r1;
  logic saw_rsp;

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;

    // Reset with every requester valid: nothing granted, outputs cleared.
    @(posedge clk); @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_fpu_a",     64'(fpu_a),     64'd0);
    check("rst_fpu_b",     64'(fpu_b),     64'd0);
    check("rst_rsp_id",    64'(rsp_id),    64'd0);
    check("rst_rsp_data",  64'(rsp_data),  64'd0);
    @(posedge clk); @(negedge clk);
    check("rst_req_ready2", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_op(0, 32'h3F000000, 32'h3E800000);
    exp_q.push_back({2'd0, 32'h3F400000});
    @(negedge clk);
    check("first_grant", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_done();

    // Single op from requester 2: 1.0 + 2.0, ptr is now 1.
    set_op(2, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0100;
    exp_q.push_back({2'd2, 32'h40400000});
    @(negedge clk);
    check("single_grant", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("single_lat0", 64'(rsp_valid), 64'd0);
    check("single_fpu_a", 64'(fpu_a), 64'h3F800000);
    @(negedge clk);
    check("single_lat1", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("single_lat2", 64'(rsp_valid), 64'd1);
    wait_done();

    // Back-pressure: requester 1 (ptr=3 wraps to 1), 1.0 + 1.0, consumer stalls 5 cycles.
    rsp_ready = 1'b0;
    set_op(1, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b0010;
    exp_q.push_back({2'd1, 32'h40000000});
    @(negedge clk);
    check("bp_grant", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    for (int j = 0; j < 5; j++) begin
      check("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check("bp_hold_data",  64'(rsp_data),  64'h40000000);
      check("bp_no_ready",   64'(req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_complete", 64'(rsp_valid), 64'd0);

    // Withdrawal: requester 1 pulses valid while requester 0's op is in WAIT.
    set_op(0, 32'h40400000, 32'h40800000);
    req_valid = 4'b0001;
    exp_q.push_back({2'd0, 32'h40E00000});
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    check("wd_wait_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    saw_r1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_ready[1]) saw_r1 = 1'b1;
    end
    check("wd_never_granted", 64'(saw_r1), 64'd0);
    wait_done();

    // Reset during WAIT: operation dropped, ptr back to 0.
    set_op(3, 32'h41200000, 32'hC0800000);
    req_valid = 4'b1000;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_fpu_a", 64'(fpu_a), 64'd0);
    saw_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) saw_rsp = 1'b1;
      @(negedge clk);
    end
    check("mid_rst_no_rsp", 64'(saw_rsp), 64'd0);

    // Round robin with all four valid: grants 0,1,2,3,0, four cycles apart.
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h40400000, 32'h40800000);
    set_op(2, 32'hBF800000, 32'h3F800000);
    set_op(3, 32'h41200000, 32'hC0800000);
    exp_q.push_back({2'd0, 32'h40400000});
    exp_q.push_back({2'd1, 32'h40E00000});
    exp_q.push_back({2'd2, 32'h00000000});
    exp_q.push_back({2'd3, 32'h40C00000});
    exp_q.push_back({2'd0, 32'h40400000});
    req_valid = 4'b1111;
    #1;
    ng = 0;
    for (int c = 0; c < 60; c++) begin
      if (req_ready != '0) begin
        gidx[ng] = oh_idx(req_ready);
        gcyc[ng] = c;
        ng++;
      end
      if (ng == 5) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid = '0;
    check("rr_grants", 64'(ng), 64'd5);
    if (ng == 5) begin
      for (int k = 0; k < 5; k++) begin
        check("rr_order", 64'(gidx[k]), 64'(order[k]));
        if (k > 0) check("rr_period", 64'(gcyc[k] - gcyc[k-1]), 64'd4);
      end
    end
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
